output_port_arbiter: RTL and testbench
======================================

// Module: output_port_arbiter
// PURPOSE
//  Shares one NoC tree output link among NUM_IN input ports (default parent/left/right) with round-robin arbitration.
//  Holds one registered output slot, so a stalled sink (e.g. data_bucket behind a sync bridge) backpressures all inputs.
//  Sits in output_control_module between the input buffers and the outgoing link.
//  Keeps saturating per-input forwarded-packet counters for throughput measurement.
// PARAMETERS
//  NUM_IN        3   number of requesting inputs; legal range 2..8
//  WIDTH_packet  14  packet (single-flit) width in bits
//  CNT_W         16  width of each per-input packet counter
// PORTS
//  clk       in   1                   clock; all state updates on rising edge
//  reset     in   1                   synchronous, active-high reset
//  in_valid  in   NUM_IN              per-input packet present
//  in_data   in   NUM_IN*WIDTH_packet packed packets; input i at [i*WIDTH_packet +: WIDTH_packet]
//  in_ready  out  NUM_IN              one-hot grant/accept; combinational
//  out_valid out  1                   output slot holds a packet
//  out_data  out  WIDTH_packet        registered packet
//  out_src   out  $clog2(NUM_IN)      index of input that supplied out_data
//  out_ready in   1                   downstream accepts out_data this cycle
//  pkt_cnt   out  NUM_IN*CNT_W        packed per-input forwarded-packet counters
// BEHAVIOUR
//  Handshake
//  - A transfer occurs on a cycle with valid && ready, on either side.
//  - Once asserted, in_valid and its in_data stay stable until accepted.
//  - in_valid must not depend on in_ready.
//  Slot FSM
//  - States: EMPTY (out_valid=0) and FULL (out_valid=1).
//  - load_en = !out_valid || out_ready, so drain and refill can happen in the same cycle.
//  Arbitration
//  - When load_en=1 and any in_valid=1, grant g = first i with in_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_IN.
//  - in_ready = onehot(g) only in that case; otherwise in_ready = 0.
//  - At most one in_ready bit is high per cycle.
//  - Next edge after a grant: out_data<=in_data[g], out_src<=g, out_valid<=1, rr_ptr<=(g+1) mod NUM_IN, pkt_cnt[g]++.
//  - rr_ptr changes only on a grant.
//  Transitions
//  - EMPTY -> FULL on a grant.
//  - FULL stays FULL while out_ready=0. out_data and out_src are held and in_ready=0.
//  - FULL -> FULL when out_ready=1 and a grant occurs (back-to-back, 1 packet/cycle).
//  - FULL -> EMPTY when out_ready=1 and no in_valid is high.
//  Timing
//  - Latency: input accept to out_valid is 1 cycle.
//  - Sustained throughput is 1 packet/cycle when out_ready=1.
//  Counters
//  - Each pkt_cnt saturates at 2^CNT_W-1 and does not wrap.
//  - A granted input whose counter is saturated is still forwarded.
//  Reset (reset=1 at an edge)
//  - out_valid=0, out_data=0, out_src=0, rr_ptr=0, all pkt_cnt=0.
//  - in_ready=0 combinationally for the whole time reset is high.
//  - A packet buffered when reset arrives mid-operation is discarded, not delivered.
//  Boundaries
//  - If all inputs request, the grant rotates 0,1,2,0,... so each input waits at most NUM_IN-1 grants.
//  - rr_ptr wrap-around: after g=NUM_IN-1, the search starts at 0.
//  - out_ready with out_valid=0 is ignored.
// TESTING
//  - Reset: hold reset 2 cycles with all in_valid=1 -> in_ready=0, out_valid=0, pkt_cnt all 0.
//  - Single input: in_valid=3'b010, data 14'h0ABC, out_ready=1 -> in_ready=3'b010.
//    Next cycle out_valid=1, out_data=14'h0ABC, out_src=1, pkt_cnt[1]=1.
//  - Fairness: all 3 inputs valid continuously, out_ready=1 for 6 cycles -> out_src sequence 0,1,2,0,1,2.
//    out_valid=1 every cycle after the first; each pkt_cnt=2.
//  - Backpressure: slot FULL with 14'h1234, out_ready=0 for 4 cycles -> out_data holds 14'h1234, in_ready=0.
//    When out_ready=1, the next grant lands in the same cycle.
//  - Skip idle: rr_ptr=2, in_valid=3'b001 -> grant 0, then rr_ptr=1.
//  - Saturation and reset mid-op: CNT_W=2, 5 grants to input 0 -> pkt_cnt[0]=3.
//    Then reset while FULL -> out_valid=0 next cycle and the packet is never delivered.

Source files
------------

// File: rtl/output_port_arbiter.sv
// Round-robin arbiter sharing one output link among NUM_IN inputs through a single
// registered output slot, with saturating per-input forwarded-packet counters.
module output_port_arbiter #(
    parameter int NUM_IN       = 3,
    parameter int WIDTH_packet = 14,
    parameter int CNT_W        = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_IN-1:0]              in_valid,
    input  logic [NUM_IN*WIDTH_packet-1:0] in_data,
    output logic [NUM_IN-1:0]              in_ready,
    output logic                           out_valid,
    output logic [WIDTH_packet-1:0]        out_data,
    output logic [$clog2(NUM_IN)-1:0]      out_src,
    input  logic                           out_ready,
    output logic [NUM_IN*CNT_W-1:0]        pkt_cnt
);

    localparam int SRC_W = $clog2(NUM_IN);
    localparam logic [SRC_W:0] NUM_IN_W = (SRC_W+1)'(NUM_IN);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]              slot_state_r;
    logic [WIDTH_packet-1:0] out_data_r;
    logic [SRC_W-1:0]        out_src_r;
    logic [SRC_W-1:0]        rr_ptr_r;
    logic [CNT_W-1:0]        cnt_r [NUM_IN];

    logic                    load_en_s;
    logic                    grant_found_s;
    logic                    grant_s;
    logic [SRC_W-1:0]        grant_idx_s;
    logic [NUM_IN-1:0]       in_ready_s;
    logic [WIDTH_packet-1:0] grant_data_s;

    // (base + off) mod NUM_IN for base < NUM_IN and off < NUM_IN
    function automatic logic [SRC_W-1:0] wrap_idx(input logic [SRC_W-1:0] base, input int off);
        logic [SRC_W:0] sum;
        sum = {1'b0, base} + off[SRC_W:0];
        if (sum >= NUM_IN_W) begin
            sum = sum - NUM_IN_W;
        end else begin
            sum = sum;
        end
        return sum[SRC_W-1:0];
    endfunction

    assign load_en_s = (slot_state_r == EMPTY) || out_ready;
    assign grant_s   = grant_found_s && load_en_s && !reset;

    // First requesting input found when searching upward from rr_ptr
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (!grant_found_s && in_valid[wrap_idx(rr_ptr_r, k)]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = wrap_idx(rr_ptr_r, k);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // One-hot accept for the granted input
    always_comb begin
        in_ready_s = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_s && (grant_idx_s == SRC_W'(i))) begin
                in_ready_s[i] = 1'b1;
            end else begin
                in_ready_s[i] = 1'b0;
            end
        end
    end

    assign grant_data_s = in_data[grant_idx_s*WIDTH_packet +: WIDTH_packet];

    // Output slot: refill on grant, drain when downstream takes it and nothing refills
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_state_r <= EMPTY;
            out_data_r   <= '0;
            out_src_r    <= '0;
            rr_ptr_r     <= '0;
        end else if (grant_s) begin
            slot_state_r <= FULL;
            out_data_r   <= grant_data_s;
            out_src_r    <= grant_idx_s;
            rr_ptr_r     <= wrap_idx(grant_idx_s, 1);
        end else if (out_ready) begin
            slot_state_r <= EMPTY;
        end else begin
            slot_state_r <= slot_state_r;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_cnt
            // Saturating forwarded-packet counter; a saturated input is still forwarded
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_r[gi] <= '0;
                end else if (in_ready_s[gi] && !(&cnt_r[gi])) begin
                    cnt_r[gi] <= cnt_r[gi] + CNT_W'(1);
                end else begin
                    cnt_r[gi] <= cnt_r[gi];
                end
            end
            assign pkt_cnt[gi*CNT_W +: CNT_W] = cnt_r[gi];
        end
    endgenerate

    assign in_ready  = in_ready_s;
    assign out_valid = (slot_state_r == FULL);
    assign out_data  = out_data_r;
    assign out_src   = out_src_r;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Self-checking bench for output_port_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural round-robin slot model.
module tb_output_port_arbiter;

    localparam int N    = 3;
    localparam int W    = 14;
    localparam int CW   = 2;
    localparam int CMAX = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [1:0]       out_src;
    logic             out_ready;
    logic [N*CW-1:0]  pkt_cnt;

    int checks = 0;
    int errors = 0;

    bit         m_valid = 1'b0;
    logic [W-1:0] m_data = '0;
    int         m_src = 0;
    int         m_rr = 0;
    int         m_cnt [N];

    always #5 clk = ~clk;

    output_port_arbiter #(.NUM_IN(N), .WIDTH_packet(W), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_src(out_src), .out_ready(out_ready), .pkt_cnt(pkt_cnt)
    );

    function automatic int model_grant();
        int idx;
        if (reset) return -1;
        if (m_valid && !out_ready) return -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (in_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = model_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [N*CW-1:0] model_cnt();
        logic [N*CW-1:0] p;
        for (int i = 0; i < N; i++) p[i*CW +: CW] = CW'(m_cnt[i]);
        return p;
    endfunction

    task automatic model_edge();
        int g;
        g = model_grant();
        if (reset) begin
            m_valid = 1'b0; m_data = '0; m_src = 0; m_rr = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = in_data[g*W +: W];
            m_src   = g;
            m_rr    = (g + 1) % N;
            if (m_cnt[g] < CMAX) m_cnt[g] = m_cnt[g] + 1;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input int i, input logic [W-1:0] d);
        in_data[i*W +: W] = d;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 3'b111; out_ready = 1'b1;
        set_in(0, 14'h0011); set_in(1, 14'h0022); set_in(2, 14'h0033);
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (in_ready !== 3'b000) begin errors++; $display("FAIL reset_in_ready got=%b exp=000", in_ready); end
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
            checks++; if (pkt_cnt !== 6'd0) begin errors++; $display("FAIL reset_pkt_cnt got=%h exp=0", pkt_cnt); end
            checks++; if (out_data !== 14'h0000) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        end
        reset = 1'b0; in_valid = 3'b000;
    endtask

    task automatic test_single();
        in_valid = 3'b010; set_in(1, 14'h0ABC); out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 3'b010) begin errors++; $display("FAIL single_in_ready got=%b exp=010", in_ready); end
        tick();
        in_valid = 3'b000;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 14'h0ABC) begin errors++; $display("FAIL single_out_data got=%h exp=0abc", out_data); end
        checks++; if (out_src !== 2'd1) begin errors++; $display("FAIL single_out_src got=%0d exp=1", out_src); end
        checks++; if (pkt_cnt[3:2] !== 2'd1) begin errors++; $display("FAIL single_pkt_cnt1 got=%0d exp=1", pkt_cnt[3:2]); end
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_r;
        logic [W-1:0] exp_d;
        reset = 1'b1; in_valid = 3'b000; #1; tick(); reset = 1'b0;
        in_valid = 3'b111; out_ready = 1'b1;
        set_in(0, 14'h0100); set_in(1, 14'h0201); set_in(2, 14'h0302);
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_r = 3'b001 << (k % 3);
            checks++; if (in_ready !== exp_r) begin errors++; $display("FAIL fair_in_ready k=%0d got=%b exp=%b", k, in_ready, exp_r); end
            tick();
            exp_d = 14'h0100 + 14'((k % 3) * 257);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fair_out_valid k=%0d got=%b exp=1", k, out_valid); end
            checks++; if (out_src !== 2'(k % 3)) begin errors++; $display("FAIL fair_out_src k=%0d got=%0d exp=%0d", k, out_src, k % 3); end
            checks++; if (out_data !== exp_d) begin errors++; $display("FAIL fair_out_data k=%0d got=%h exp=%h", k, out_data, exp_d); end
        end
        checks++; if (pkt_cnt !== 6'b10_10_10) begin errors++; $display("FAIL fair_pkt_cnt got=%b exp=101010", pkt_cnt); end
        in_valid = 3'b000;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fair_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        in_valid = 3'b001; set_in(0, 14'h1234); out_ready = 1'b1;
        tick();
        in_valid = 3'b010; set_in(1, 14'h0555); out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (in_ready !== 3'b000) begin errors++; $display("FAIL bp_in_ready c=%0d got=%b exp=000", c, in_ready); end
            tick();
            checks++; if (out_data !== 14'h1234 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold c=%0d got=%h/%b exp=1234/1", c, out_data, out_valid); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 3'b010) begin errors++; $display("FAIL bp_release_ready got=%b exp=010", in_ready); end
        tick();
        checks++; if (out_data !== 14'h0555 || out_src !== 2'd1) begin errors++; $display("FAIL bp_next got=%h/%0d exp=0555/1", out_data, out_src); end
        in_valid = 3'b000;
        tick();
    endtask

    task automatic test_skip_idle();
        in_valid = 3'b001; set_in(0, 14'h0077); out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 3'b001) begin errors++; $display("FAIL skip_in_ready got=%b exp=001", in_ready); end
        tick();
        checks++; if (out_src !== 2'd0 || out_data !== 14'h0077) begin errors++; $display("FAIL skip_out got=%0d/%h exp=0/0077", out_src, out_data); end
        in_valid = 3'b111;
        #1;
        checks++; if (in_ready !== 3'b010) begin errors++; $display("FAIL skip_rr_next got=%b exp=010", in_ready); end
        tick();
        in_valid = 3'b000;
        tick();
    endtask

    task automatic test_saturation_reset();
        reset = 1'b1; #1; tick(); reset = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 3'b001; set_in(0, 14'h0200 + 14'(k));
            #1;
            checks++; if (in_ready !== 3'b001) begin errors++; $display("FAIL sat_in_ready k=%0d got=%b exp=001", k, in_ready); end
            tick();
            checks++; if (out_data !== 14'h0200 + 14'(k)) begin errors++; $display("FAIL sat_forward k=%0d got=%h exp=%h", k, out_data, 14'h0200 + 14'(k)); end
        end
        checks++; if (pkt_cnt[1:0] !== 2'd3) begin errors++; $display("FAIL sat_pkt_cnt0 got=%0d exp=3", pkt_cnt[1:0]); end
        in_valid = 3'b000; out_ready = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sat_full_hold got=%b exp=1", out_valid); end
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 3'b000) begin errors++; $display("FAIL midrst_in_ready got=%b exp=000", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
        reset = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_deliver c=%0d got=%b exp=0", c, out_valid); end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] exp_r;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!in_valid[i] && $urandom_range(0, 2) == 0) begin
                    in_valid[i] = 1'b1;
                    set_in(i, W'($urandom));
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 60) == 0);
            #1;
            exp_r = model_ready();
            checks++; if (in_ready !== exp_r) begin errors++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_r); end
            tick();
            checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, m_valid); end
            checks++; if (out_data !== m_data || out_src !== 2'(m_src)) begin errors++; $display("FAIL rand_out cyc=%0d got=%h/%0d exp=%h/%0d", cyc, out_data, out_src, m_data, m_src); end
            checks++; if (pkt_cnt !== model_cnt()) begin errors++; $display("FAIL rand_pkt_cnt cyc=%0d got=%b exp=%b", cyc, pkt_cnt, model_cnt()); end
            in_valid = in_valid & ~exp_r;
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_skip_idle();
        test_saturation_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
